// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC SPI capture block
package adc_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } adc_state_t;

    localparam int ADC_SAMPLE_W = 16;
    localparam int ADC_BITS     = 16;

endpackage

// File: rtl/adc_spi_capture_sck_gen.sv
// rtl/adc_spi_capture_sck_gen.sv - serial clock divider with edge strobes
//
// Ports:
//   i_clk, i_rst_n  system clock, asynchronous active-low reset
//   i_clear         synchronous clear: holds sck low and the divider at zero
//   o_sck           registered serial clock, idles low
//   o_rise_stb      high for the first clk cycle of each sck high phase
//   o_fall_stb      high for the last clk cycle of each sck high phase
//                   (sck falls on the clk edge that ends this cycle)
module sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_sck,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_wrap;

    assign w_wrap = (r_cnt == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // The divider count is only zero right after a toggle while running,
    // so sck high with a zero count marks the cycle following the rise.
    // Sampling miso here keeps it well clear of the ADC's falling-edge update.
    assign o_rise_stb = r_sck && (r_cnt == '0);
    assign o_fall_stb = r_sck && w_wrap;
    assign o_sck      = r_sck;

endmodule

// File: rtl/adc_spi_capture.sv
// rtl/adc_spi_capture.sv - SPI master capturing 16-bit ADC samples onto a valid/ready port
//
// Ports:
//   i_clk, i_rst_n    system clock, asynchronous active-low reset
//   i_enable          run request; low aborts the current frame
//   i_miso            serial data from the ADC, MSB first
//   o_sck             serial clock, idles low
//   o_adc_en          converter enable, high for the whole frame
//   o_sample          last captured word
//   o_sample_valid    o_sample holds an unconsumed word
//   i_sample_ready    downstream accepts o_sample
//   o_overrun         one-cycle pulse when an unconsumed word is overwritten
module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_miso,
    output logic                    o_sck,
    output logic                    o_adc_en,
    output logic [ADC_SAMPLE_W-1:0] o_sample,
    output logic                    o_sample_valid,
    input  logic                    i_sample_ready,
    output logic                    o_overrun
);

    localparam int BW = $clog2(ADC_BITS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(ADC_BITS - 1);
    localparam logic [BW-1:0] BIT_DONE = BW'(ADC_BITS);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    adc_state_t              r_state;
    logic                    r_adc_en;
    logic [ADC_SAMPLE_W-1:0] r_shreg;
    logic [ADC_SAMPLE_W-1:0] r_sample;
    logic                    r_sample_valid;
    logic                    r_overrun;
    logic [BW-1:0]           r_bit_cnt;   // rises seen this frame, 0..16
    logic [GW-1:0]           r_gap_cnt;

    logic w_run;
    logic w_sck;
    logic w_rise_stb;
    logic w_fall_stb;
    logic w_load;

    // The divider only runs while a frame is shifting; dropping enable
    // clears it on the same edge the FSM returns to IDLE so sck drops at once.
    assign w_run  = (r_state == SHIFT) && i_enable;
    assign w_load = w_run && w_rise_stb && (r_bit_cnt == BIT_LAST);

    sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (!w_run),
        .o_sck      (w_sck),
        .o_rise_stb (w_rise_stb),
        .o_fall_stb (w_fall_stb)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_adc_en       <= 1'b0;
            r_shreg        <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
            r_bit_cnt      <= '0;
            r_gap_cnt      <= '0;
        end else begin
            // Output register: a load beats a coincident handshake, and only
            // a load onto an unaccepted word counts as an overrun.
            r_overrun <= 1'b0;
            if (w_load) begin
                r_sample       <= {r_shreg[ADC_SAMPLE_W-2:0], i_miso};
                r_sample_valid <= 1'b1;
                r_overrun      <= r_sample_valid && !i_sample_ready;
            end else if (r_sample_valid && i_sample_ready) begin
                r_sample_valid <= 1'b0;
            end

            if (!i_enable) begin
                r_state  <= IDLE;
                r_adc_en <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= SHIFT;
                        r_adc_en  <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                    SHIFT: begin
                        if (w_rise_stb) begin
                            r_shreg   <= {r_shreg[ADC_SAMPLE_W-2:0], i_miso};
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                        // adc_en drops on the same edge as the last sck fall
                        if (w_fall_stb && (r_bit_cnt == BIT_DONE)) begin
                            r_state   <= GAP;
                            r_adc_en  <= 1'b0;
                            r_gap_cnt <= '0;
                        end
                    end
                    GAP: begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_state   <= SHIFT;
                            r_adc_en  <= 1'b1;
                            r_bit_cnt <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GW'(1);
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_adc_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_sck          = w_sck;
    assign o_adc_en       = r_adc_en;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb/tb_adc_spi_capture.sv - self-checking bench for adc_spi_capture
module tb_adc_spi_capture;

    localparam int D     = 4;
    localparam int G     = 8;
    localparam int P     = 32*D + G + 1;
    localparam int NEVER = 32'h3fff_ffff;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        miso   = 1'b0;
    logic        ready  = 1'b0;
    logic        sck, adc_en, valid, ovr;
    logic [15:0] sample;

    logic        en2   = 1'b0;
    logic        miso2 = 1'b0;
    logic        sck2, adc_en2, valid2, ovr2;
    logic [15:0] sample2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    adc_spi_capture #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_miso         (miso),
        .o_sck          (sck),
        .o_adc_en       (adc_en),
        .o_sample       (sample),
        .o_sample_valid (valid),
        .i_sample_ready (ready),
        .o_overrun      (ovr)
    );

    adc_spi_capture #(.CLK_DIV(2), .GAP_CYCLES(8)) dut2 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (en2),
        .i_miso         (miso2),
        .o_sck          (sck2),
        .o_adc_en       (adc_en2),
        .o_sample       (sample2),
        .o_sample_valid (valid2),
        .i_sample_ready (1'b1),
        .o_overrun      (ovr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ADC models: present the MSB when enabled, next bit after each sck fall
    logic [15:0] adc_q[$];
    logic [15:0] adc_cur = 16'h0;
    int          adc_bit = 0;
    always @(posedge adc_en) begin
        adc_cur = (adc_q.size() > 0) ? adc_q.pop_front() : 16'($urandom);
        adc_bit = 15;
        miso    = adc_cur[15];
    end
    always @(negedge sck) if (adc_bit > 0) begin
        adc_bit = adc_bit - 1;
        miso    = adc_cur[adc_bit];
    end

    logic [15:0] adc2_word = 16'hA5C3;
    int          adc2_bit  = 0;
    always @(posedge adc_en2) begin
        adc2_bit = 15;
        miso2    = adc2_word[15];
    end
    always @(negedge sck2) if (adc2_bit > 0) begin
        adc2_bit = adc2_bit - 1;
        miso2    = adc2_word[adc2_bit];
    end

    // Reference model: frame n of a run starts at t0 + n*P; within a frame,
    // sck is high in odd CLK_DIV slots, adc_en for 32*D cycles, and the word
    // lands at offset 31*D+1.  Runs end when enable is seen low (mdl_stop).
    logic [15:0] mdl_words[$];
    logic [15:0] cap_q[$];
    int          mdl_t0   = NEVER;
    int          mdl_stop = NEVER;
    int          ovr_cnt  = 0;
    logic        m_valid  = 1'b0;
    logic        m_prev_ready = 1'b0;
    logic [15:0] m_word   = 16'h0;

    always @(negedge clk) begin : model
        int   n, o;
        logic e_adc, e_sck, e_ovr, ld;
        if (!rst_n) begin
            m_valid      = 1'b0;
            m_word       = 16'h0;
            m_prev_ready = 1'b0;
        end else begin
            e_adc = 1'b0; e_sck = 1'b0; e_ovr = 1'b0; ld = 1'b0;
            n = 0; o = 0;
            if (cyc >= mdl_t0 && cyc < mdl_stop) begin
                n     = (cyc - mdl_t0) / P;
                o     = (cyc - mdl_t0) % P;
                e_adc = (o < 32*D);
                e_sck = e_adc && (o >= D) && (((o / D) % 2) == 1);
                ld    = (o == 31*D + 1);
            end
            if (ld) begin
                e_ovr   = m_valid && !m_prev_ready;
                m_valid = 1'b1;
                m_word  = (n < mdl_words.size()) ? mdl_words[n] : 16'h0;
            end else if (m_valid && m_prev_ready) begin
                m_valid = 1'b0;
            end
            m_prev_ready = ready;
            check_eq("adc_en",  32'(adc_en), 32'(e_adc));
            check_eq("sck",     32'(sck),    32'(e_sck));
            check_eq("valid",   32'(valid),  32'(m_valid));
            check_eq("sample",  32'(sample), 32'(m_word));
            check_eq("overrun", 32'(ovr),    32'(e_ovr));
            if (valid && ready) cap_q.push_back(sample);
            if (ovr) ovr_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic prep_run();
        mdl_words.delete();
    endtask

    task automatic add_word(input logic [15:0] w);
        mdl_words.push_back(w);
        adc_q.push_back(w);
    endtask

    task automatic start_run();
        enable   = 1'b1;
        mdl_stop = NEVER;
        mdl_t0   = cyc + 1;
    endtask

    task automatic stop_run();
        enable   = 1'b0;
        mdl_stop = cyc + 1;
    endtask

    function automatic logic [31:0] cap_at(input int i);
        return (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hDEAD_0000;
    endfunction

    task automatic run_div2();
        int a_rise = -1, a_fall = -1, v_rise = -1, rises = 0;
        logic [15:0] got = 16'h0;
        logic pa = 1'b0, ps = 1'b0, pv = 1'b0;
        en2 = 1'b1;
        for (int t = 0; t < 300 && a_fall < 0; t++) begin
            @(negedge clk);
            if (adc_en2 && !pa) a_rise = t;
            if (!adc_en2 && pa) a_fall = t;
            if (sck2 && !ps) rises++;
            if (valid2 && !pv) begin v_rise = t; got = sample2; end
            pa = adc_en2; ps = sck2; pv = valid2;
        end
        en2 = 1'b0;
        check_eq("d2_adc_en_latency", 32'(a_rise), 32'd1);
        check_eq("d2_valid_latency",  32'(v_rise - a_rise), 32'd63);
        check_eq("d2_sck_rises",      32'(rises), 32'd16);
        check_eq("d2_sample",         32'(got), 32'hA5C3);
        check_eq("d2_adc_en_fall",    32'(a_fall - v_rise), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin : stim
        int c0, o0, t0;
        repeat (3) step();
        check_eq("rst_sck",     32'(sck),    32'd0);
        check_eq("rst_adc_en",  32'(adc_en), 32'd0);
        check_eq("rst_sample",  32'(sample), 32'd0);
        check_eq("rst_valid",   32'(valid),  32'd0);
        check_eq("rst_overrun", 32'(ovr),    32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // Single frame at CLK_DIV=2
        run_div2();
        repeat (20) step();

        // Continuous run, ready high
        ready = 1'b1;
        c0 = cap_q.size();
        prep_run();
        add_word(16'h0001); add_word(16'h8000); add_word(16'hFFFF);
        start_run();
        t0 = mdl_t0;
        wait_cyc(t0 + 2*P + 32*D + 2);
        stop_run();
        step();
        check_eq("cont_count", 32'(cap_q.size() - c0), 32'd3);
        check_eq("cont_w0", cap_at(c0),     32'h0001);
        check_eq("cont_w1", cap_at(c0 + 1), 32'h8000);
        check_eq("cont_w2", cap_at(c0 + 2), 32'hFFFF);
        repeat (5) step();

        // Backpressure across two frames
        ready = 1'b0;
        o0 = ovr_cnt;
        c0 = cap_q.size();
        prep_run();
        add_word(16'h1234); add_word(16'hBEEF);
        start_run();
        t0 = mdl_t0;
        wait_cyc(t0 + P + 32*D + 2);
        stop_run();
        step();
        check_eq("bp_overruns", 32'(ovr_cnt - o0), 32'd1);
        check_eq("bp_sample",   32'(sample), 32'hBEEF);
        check_eq("bp_valid",    32'(valid),  32'd1);
        ready = 1'b1;
        step();
        check_eq("bp_cleared",  32'(valid), 32'd0);
        check_eq("bp_count",    32'(cap_q.size() - c0), 32'd1);
        check_eq("bp_word",     cap_at(c0), 32'hBEEF);
        repeat (3) step();

        // Handshake exactly on the second load
        ready = 1'b0;
        o0 = ovr_cnt;
        c0 = cap_q.size();
        prep_run();
        add_word(16'h3C3C); add_word(16'h9F01);
        start_run();
        t0 = mdl_t0;
        wait_cyc(t0 + P + 31*D);
        ready = 1'b1;
        step();
        ready = 1'b0;
        wait_cyc(t0 + P + 32*D + 2);
        stop_run();
        step();
        check_eq("co_overruns", 32'(ovr_cnt - o0), 32'd0);
        check_eq("co_valid",    32'(valid), 32'd1);
        ready = 1'b1;
        step();
        step();
        check_eq("co_count", 32'(cap_q.size() - c0), 32'd2);
        check_eq("co_w0",    cap_at(c0),     32'h3C3C);
        check_eq("co_w1",    cap_at(c0 + 1), 32'h9F01);

        // Abort after the 7th sck rise, then a clean frame
        c0 = cap_q.size();
        prep_run();
        add_word(16'h7777);
        start_run();
        t0 = mdl_t0;
        wait_cyc(t0 + 13*D + 1);
        stop_run();
        step();
        check_eq("ab_sck",    32'(sck),    32'd0);
        check_eq("ab_adc_en", 32'(adc_en), 32'd0);
        repeat (30) step();
        check_eq("ab_no_word", 32'(cap_q.size() - c0), 32'd0);
        prep_run();
        add_word(16'h6B2D);
        start_run();
        t0 = mdl_t0;
        wait_cyc(t0 + 32*D + 2);
        stop_run();
        step();
        check_eq("ab_next_count", 32'(cap_q.size() - c0), 32'd1);
        check_eq("ab_next_word",  cap_at(c0), 32'h6B2D);

        // Reset in the middle of a frame
        prep_run();
        add_word(16'h5A5A);
        start_run();
        t0 = mdl_t0;
        wait_cyc(t0 + 40);
        rst_n    = 1'b0;
        enable   = 1'b0;
        mdl_t0   = NEVER;
        mdl_stop = NEVER;
        #1;
        check_eq("mr_sck",     32'(sck),    32'd0);
        check_eq("mr_adc_en",  32'(adc_en), 32'd0);
        check_eq("mr_sample",  32'(sample), 32'd0);
        check_eq("mr_valid",   32'(valid),  32'd0);
        check_eq("mr_overrun", 32'(ovr),    32'd0);
        step();
        rst_n = 1'b1;
        c0 = cap_q.size();
        repeat (40) step();
        check_eq("mr_no_word", 32'(cap_q.size() - c0), 32'd0);
        prep_run();
        add_word(16'hC0DE);
        start_run();
        t0 = mdl_t0;
        wait_cyc(t0 + 32*D + 2);
        stop_run();
        step();
        check_eq("mr_next_word", cap_at(c0), 32'hC0DE);

        // Randomized words and randomized backpressure
        prep_run();
        for (int i = 0; i < 6; i++) add_word(16'($urandom));
        start_run();
        t0 = mdl_t0;
        while (cyc < t0 + 5*P + 32*D + 2) begin
            ready = 1'($urandom_range(0, 1));
            step();
        end
        stop_run();
        ready = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
